// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants.
// Adder mode encodings used by ALU, PC logic and seq_chunk_adder.
package riscv_pkg;

  localparam logic [1:0] ADD_MODE = 2'b00;
  localparam logic [1:0] INC_MODE = 2'b01;
  localparam logic [1:0] SUB_MODE = 2'b10;
  localparam logic [1:0] RSV_MODE = 2'b11;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result handshake bundle for seq_chunk_adder.
// master = requester/consumer side, slave = adder side.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, mode, in1, in2, out_ready,
    input  in_ready, out_valid, out,
    input  carry_out, overflow, err
  );

  modport slave (
    input  in_valid, mode, in1, in2, out_ready,
    output in_ready, out_valid, out,
    output carry_out, overflow, err
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit full adder slice.
// Reused every RUN cycle by seq_chunk_adder.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle ADD/INC/SUB adder, CHUNK bits per cycle.
// Reports carry, signed overflow and reserved-mode error.
module seq_chunk_adder
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int STEP  = 4
) (
  input  logic clk,
  input  logic rst,
  seq_chunk_adder_if.slave bus
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int MSB = WIDTH - 1;

  if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_chk
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, full_res;
  logic [IW-1:0]    idx_q;
  logic             carry_q, err_pend_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_out_q, overflow_q, err_q;
  logic             out_valid_q, in_ready_q;

  logic [CHUNK-1:0] ca, cb, csum;
  logic             ccout;
  logic             last, accept, finish;

  assign ca   = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign cb   = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last = (idx_q == IW'(NUM_CHUNKS - 1));

  adder_chunk #(.W(CHUNK)) u_chunk (
    .a   (ca),
    .b   (cb),
    .cin (carry_q),
    .sum (csum),
    .cout(ccout)
  );

  // Partial result with the current chunk's sum merged in.
  always_comb begin
    full_res = res_q;
    full_res[int'(idx_q)*CHUNK +: CHUNK] = csum;
  end

  // Next state and handshake qualifiers.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch, chunk iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      err_pend_q  <= 1'b0;
      out_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        a_q        <= bus.in1;
        res_q      <= '0;
        idx_q      <= '0;
        err_pend_q <= (bus.mode == RSV_MODE);
        unique case (1'b1)
          (bus.mode == INC_MODE): begin
            b_q     <= WIDTH'(STEP);
            carry_q <= 1'b0;
          end
          (bus.mode == SUB_MODE): begin
            b_q     <= ~bus.in2;
            carry_q <= 1'b1;
          end
          default: begin
            b_q     <= bus.in2;
            carry_q <= 1'b0;
          end
        endcase
      end
      if (state_q == RUN) begin
        res_q   <= full_res;
        carry_q <= ccout;
        if (!last) idx_q <= idx_q + 1'b1;
      end
      if (finish) begin
        out_q       <= full_res;
        carry_out_q <= ccout;
        overflow_q  <= (a_q[MSB] == b_q[MSB]) &&
                       (full_res[MSB] != a_q[MSB]);
        err_q       <= err_pend_q;
        out_valid_q <= 1'b1;
      end else if ((state_q == DONE) && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed scoreboard bench for seq_chunk_adder.
// Covers CHUNK=8 (latency 4) and CHUNK=32 (latency 1).
module tb_seq_chunk_adder;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(32)) b8 ();
  seq_chunk_adder_if #(.WIDTH(32)) b32 ();

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8), .STEP(4)) dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave)
  );
  seq_chunk_adder #(.WIDTH(32), .CHUNK(32), .STEP(4)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave)
  );

  logic [1:0]  mode;
  logic [31:0] in1, in2;
  logic        out_ready, v8, v32, sel;

  assign b8.mode = mode;
  assign b8.in1 = in1;
  assign b8.in2 = in2;
  assign b8.out_ready = out_ready;
  assign b8.in_valid = v8;
  assign b32.mode = mode;
  assign b32.in1 = in1;
  assign b32.in2 = in2;
  assign b32.out_ready = out_ready;
  assign b32.in_valid = v32;

  logic        o_valid, i_ready, o_c, o_v, o_e;
  logic [31:0] o_out;
  assign o_valid = sel ? b32.out_valid : b8.out_valid;
  assign i_ready = sel ? b32.in_ready : b8.in_ready;
  assign o_out   = sel ? b32.out : b8.out;
  assign o_c     = sel ? b32.carry_out : b8.carry_out;
  assign o_v     = sel ? b32.overflow : b8.overflow;
  assign o_e     = sel ? b32.err : b8.err;

  typedef struct packed {
    logic [31:0] out;
    logic        c;
    logic        v;
    logic        e;
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t r;
    longint sa, sb, s;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.e = (m == RSV_MODE);
    case (m)
      INC_MODE: begin
        u = {1'b0, a} + 33'd4;
        r.c = u[32];
        s = sa + 4;
      end
      SUB_MODE: begin
        u = {1'b0, a} - {1'b0, b};
        r.c = (a >= b);
        s = sa - sb;
      end
      default: begin
        u = {1'b0, a} + {1'b0, b};
        r.c = u[32];
        s = sa + sb;
      end
    endcase
    r.out = u[31:0];
    r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  // Issue one request, optionally disturb inputs and apply back-pressure.
  task automatic txn(input logic [1:0] m, input logic [31:0] a,
                     input logic [31:0] b, input bit toggle,
                     input int hold, input int lat);
    int n;
    exp_t ex;
    logic [31:0] held;
    n = 0;
    while (!i_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 32'(i_ready), 32'd1);
    mode = m;
    in1 = a;
    in2 = b;
    out_ready = (hold == 0);
    if (sel) v32 = 1'b1;
    else v8 = 1'b1;
    @(posedge clk);
    scb.push_back(model(m, a, b));
    @(negedge clk);
    v8 = 1'b0;
    v32 = 1'b0;
    if (toggle) begin
      in1 = ~a;
      in2 = a ^ b;
      mode = SUB_MODE;
    end
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(lat));
    if (hold > 0) begin
      held = o_out;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid", 32'(o_valid), 32'd1);
        chk("bp_out", o_out, held);
        chk("bp_in_ready", 32'(i_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    ex = scb.pop_front();
    chk("out", o_out, ex.out);
    chk("carry_out", 32'(o_c), 32'(ex.c));
    chk("overflow", 32'(o_v), 32'(ex.v));
    chk("err", 32'(o_e), 32'(ex.e));
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 32'(o_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    sel = 1'b0;
    v8 = 1'b0;
    v32 = 1'b0;
    mode = ADD_MODE;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready8", 32'(b8.in_ready), 32'd0);
    chk("rst_in_ready32", 32'(b32.in_ready), 32'd0);
    chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_out", b8.out, 32'd0);
    chk("rst_flags",
        32'({b8.carry_out, b8.overflow, b8.err}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst8", 32'(b8.in_ready), 32'd1);
    chk("in_ready_after_rst32", 32'(b32.in_ready), 32'd1);

    txn(INC_MODE, 32'd10, 32'hDEAD_BEEF, 0, 0, 4);
    txn(ADD_MODE, 32'd20, 32'd30, 0, 0, 4);
    txn(ADD_MODE, 32'hFFFF_FFFF, 32'd1, 0, 0, 4);
    txn(ADD_MODE, 32'h7FFF_FFFF, 32'd1, 0, 0, 4);
    txn(SUB_MODE, 32'd5, 32'd7, 0, 0, 4);
    txn(SUB_MODE, 32'h8000_0000, 32'd1, 0, 0, 4);
    txn(ADD_MODE, 32'h1234_5678, 32'h0F0F_F0F0, 1, 10, 4);
    txn(RSV_MODE, 32'd1, 32'd2, 0, 0, 4);

    // Abort a request in its second RUN cycle.
    mode = ADD_MODE;
    in1 = 32'd100;
    in2 = 32'd200;
    v8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 32'(b8.out_valid), 32'd0);
    chk("abort_out", b8.out, 32'd0);
    chk("abort_err", 32'(b8.err), 32'd0);
    chk("abort_flags", 32'({b8.carry_out, b8.overflow}), 32'd0);
    chk("abort_in_ready", 32'(b8.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready_after", 32'(b8.in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      if (b8.out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    txn(ADD_MODE, 32'hCAFE_0000, 32'h0000_BABE, 0, 0, 4);

    sel = 1'b1;
    txn(RSV_MODE, 32'd1, 32'd2, 0, 0, 1);
    txn(ADD_MODE, 32'h7FFF_FFFF, 32'd1, 0, 0, 1);
    txn(SUB_MODE, 32'd5, 32'd7, 0, 3, 1);
    txn(INC_MODE, 32'hFFFF_FFFC, 32'd0, 1, 0, 1);

    chk("scb_empty", 32'(scb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
